// File: rtl/dp_pkg.sv
// Shared types, width derivations and arithmetic helpers for the streaming
// dot-product engine.
package dp_pkg;

  localparam int SAT_MAX_W = 64;

  localparam logic signed [SAT_MAX_W-1:0] RELU_FLOOR = '0;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } fsm_state_t;

  typedef struct packed {
    logic first;
    logic last;
    logic relu;
  } beat_tag_t;

  // Signed weight times zero-extended unsigned pixel.
  function automatic int prod_w(input int pixel_w, input int weight_w);
    return weight_w + pixel_w + 1;
  endfunction

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic logic signed [SAT_MAX_W-1:0] saturate(
    input logic signed [SAT_MAX_W-1:0] value,
    input int                          width
  );
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  function automatic logic is_clipped(
    input logic signed [SAT_MAX_W-1:0] value,
    input int                          width
  );
    return saturate(value, width) != value;
  endfunction

endpackage

// File: rtl/dp_lane_mul_pipe.sv
// Per-lane multipliers and lane adder tree followed by a MUL_DELAY-deep
// register pipeline carrying valid and beat tags; freezes when en is low.
module dp_lane_mul_pipe
  import dp_pkg::*;
#(
  parameter int LANES     = 1,
  parameter int PIXEL_W   = 10,
  parameter int WEIGHT_W  = 19,
  parameter int MUL_DELAY = 6,
  parameter int ACC_W     = 40
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        in_valid,
  input  beat_tag_t                   in_tag,
  input  logic [LANES*PIXEL_W-1:0]    in_pixels,
  input  logic [LANES*WEIGHT_W-1:0]   in_weights,
  output logic                        out_valid,
  output beat_tag_t                   out_tag,
  output logic signed [ACC_W-1:0]     out_sum
);

  localparam int PROD_W = prod_w(PIXEL_W, WEIGHT_W);

  logic signed [PROD_W-1:0] lane_prod [LANES];
  logic signed [ACC_W-1:0]  sum_c;

  logic                     vld_q [MUL_DELAY];
  beat_tag_t                tag_q [MUL_DELAY];
  logic signed [ACC_W-1:0]  sum_q [MUL_DELAY];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [WEIGHT_W-1:0] w;
    logic signed [PIXEL_W:0]    p;
    assign w = $signed(in_weights[lane_lsb(gi, WEIGHT_W) +: WEIGHT_W]);
    assign p = $signed({1'b0, in_pixels[lane_lsb(gi, PIXEL_W) +: PIXEL_W]});
    assign lane_prod[gi] = PROD_W'(w) * PROD_W'(p);
  end

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < LANES; k++) begin
      sum_c = sum_c + ACC_W'(lane_prod[k]);
    end
  end

  // The multiply/add logic feeds a plain delay line so synthesis can retime
  // it across the MUL_DELAY stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_DELAY; i++) begin
        vld_q[i] <= 1'b0;
        tag_q[i] <= '0;
        sum_q[i] <= '0;
      end
    end else if (en) begin
      vld_q[0] <= in_valid;
      tag_q[0] <= in_tag;
      sum_q[0] <= sum_c;
      for (int i = 1; i < MUL_DELAY; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
        sum_q[i] <= sum_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[MUL_DELAY-1];
  assign out_tag   = tag_q[MUL_DELAY-1];
  assign out_sum   = sum_q[MUL_DELAY-1];

endmodule

// File: rtl/dot_product_stream.sv
// Streaming fixed-point dot product: tags beats into vectors, accumulates
// them, and emits one saturated (optionally ReLU'd) result per vector.
module dot_product_stream
  import dp_pkg::*;
#(
  parameter int LANES       = 1,
  parameter int PIXEL_W     = 10,
  parameter int WEIGHT_W    = 19,
  parameter int WEIGHT_FRAC = 16,
  parameter int MUL_DELAY   = 6,
  parameter int ACC_W       = 40,
  parameter int OUT_W       = 26,
  parameter int MAX_LEN     = 1024,
  localparam int LEN_W      = len_w(MAX_LEN)
) (
  input  logic                      clk,
  input  logic                      GlobalReset,
  input  logic [LEN_W-1:0]          cfg_len,
  input  logic                      cfg_relu,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*PIXEL_W-1:0]  in_pixels,
  input  logic [LANES*WEIGHT_W-1:0] in_weights,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_value,
  output logic                      out_sat
);

  if (MUL_DELAY < 1 || WEIGHT_FRAC >= WEIGHT_W || OUT_W > ACC_W) begin : g_bad_params
    $error("dot_product_stream: illegal parameter set");
  end

  fsm_state_t                  state_reg;
  logic [LEN_W-1:0]            len_reg;
  logic                        relu_reg;
  logic [LEN_W-1:0]            cnt_reg;
  logic                        rdy_en_reg;

  logic                        cap_valid_reg;
  beat_tag_t                   cap_tag_reg;
  logic [LANES*PIXEL_W-1:0]    cap_pix_reg;
  logic [LANES*WEIGHT_W-1:0]   cap_wt_reg;

  logic                        pipe_valid;
  beat_tag_t                   pipe_tag;
  logic signed [ACC_W-1:0]     pipe_sum;

  logic signed [ACC_W-1:0]     acc_reg;
  logic                        acc_valid_reg;
  logic                        acc_last_reg;
  logic                        acc_relu_reg;

  logic                        acc_done;
  logic                        stall;
  logic                        fire;
  logic [LEN_W-1:0]            first_len;
  logic [LEN_W-1:0]            cnt_next;
  logic signed [SAT_MAX_W-1:0] v_ext;

  // A finished vector waiting behind an unconsumed result freezes everything.
  assign acc_done  = acc_valid_reg & acc_last_reg;
  assign stall     = out_valid & ~out_ready & acc_done;
  assign in_ready  = rdy_en_reg & ~stall;
  assign fire      = in_valid & in_ready;
  assign first_len = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign cnt_next  = cnt_reg + LEN_W'(1);

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      relu_reg      <= 1'b0;
      cnt_reg       <= '0;
      rdy_en_reg    <= 1'b0;
      cap_valid_reg <= 1'b0;
      cap_tag_reg   <= '0;
      cap_pix_reg   <= '0;
      cap_wt_reg    <= '0;
    end else begin
      rdy_en_reg <= 1'b1;
      if (!stall) cap_valid_reg <= fire;
      if (fire) begin
        cap_pix_reg <= in_pixels;
        cap_wt_reg  <= in_weights;
        case (state_reg)
          IDLE: begin
            len_reg     <= first_len;
            relu_reg    <= cfg_relu;
            cnt_reg     <= LEN_W'(1);
            cap_tag_reg <= '{first: 1'b1, last: (first_len == LEN_W'(1)), relu: cfg_relu};
            state_reg   <= (first_len == LEN_W'(1)) ? IDLE : ACCUM;
          end
          ACCUM: begin
            cnt_reg     <= cnt_next;
            cap_tag_reg <= '{first: 1'b0, last: (cnt_next == len_reg), relu: relu_reg};
            if (cnt_next == len_reg) state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  dp_lane_mul_pipe #(
    .LANES     (LANES),
    .PIXEL_W   (PIXEL_W),
    .WEIGHT_W  (WEIGHT_W),
    .MUL_DELAY (MUL_DELAY),
    .ACC_W     (ACC_W)
  ) u_mul_pipe (
    .clk        (clk),
    .rst_n      (GlobalReset),
    .en         (~stall),
    .in_valid   (cap_valid_reg),
    .in_tag     (cap_tag_reg),
    .in_pixels  (cap_pix_reg),
    .in_weights (cap_wt_reg),
    .out_valid  (pipe_valid),
    .out_tag    (pipe_tag),
    .out_sum    (pipe_sum)
  );

  always_comb begin
    v_ext = SAT_MAX_W'(acc_reg);
    if (acc_relu_reg && v_ext < RELU_FLOOR) v_ext = RELU_FLOOR;
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      acc_reg       <= '0;
      acc_valid_reg <= 1'b0;
      acc_last_reg  <= 1'b0;
      acc_relu_reg  <= 1'b0;
      out_valid     <= 1'b0;
      out_value     <= '0;
      out_sat       <= 1'b0;
    end else if (!stall) begin
      acc_valid_reg <= pipe_valid;
      acc_last_reg  <= pipe_valid & pipe_tag.last;
      acc_relu_reg  <= pipe_tag.relu;
      if (pipe_valid) acc_reg <= pipe_tag.first ? pipe_sum : acc_reg + pipe_sum;
      // Loading on the same cycle the old result drains avoids a bubble.
      if (acc_done) begin
        out_valid <= 1'b1;
        out_value <= OUT_W'(saturate(v_ext, OUT_W));
        out_sat   <= is_clipped(v_ext, OUT_W);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dot_product_stream.sv
// Directed bench for dot_product_stream: a per-vector arithmetic model feeds
// an expected-result queue checked against every handshaken output.
module tb_dot_product_stream;

  localparam int LANES     = 4;
  localparam int PIXEL_W   = 10;
  localparam int WEIGHT_W  = 19;
  localparam int MUL_DELAY = 6;
  localparam int OUT_W     = 26;
  localparam int LEN_W     = 11;

  logic                      clk = 1'b0;
  logic                      GlobalReset = 1'b0;
  logic [LEN_W-1:0]          cfg_len = '0;
  logic                      cfg_relu = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [LANES*PIXEL_W-1:0]  in_pixels = '0;
  logic [LANES*WEIGHT_W-1:0] in_weights = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b1;
  logic [OUT_W-1:0]          out_value;
  logic                      out_sat;

  always #5 clk = ~clk;

  dot_product_stream #(
    .LANES(LANES), .PIXEL_W(PIXEL_W), .WEIGHT_W(WEIGHT_W), .WEIGHT_FRAC(16),
    .MUL_DELAY(MUL_DELAY), .ACC_W(40), .OUT_W(OUT_W), .MAX_LEN(1024)
  ) dut (
    .clk(clk), .GlobalReset(GlobalReset), .cfg_len(cfg_len), .cfg_relu(cfg_relu),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixels(in_pixels),
    .in_weights(in_weights), .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_sat(out_sat)
  );

  int  vpix [16][LANES];
  int  vwt  [16][LANES];
  int  exp_val_q [$];
  bit  exp_sat_q [$];
  int  got_val_q [$];
  bit  got_sat_q [$];
  int  errors = 0;
  int  checks = 0;
  time last_acc_time = 0;
  time rise_time = 0;
  bit  prev_valid = 0;
  bit  hold_prev = 0;
  int  held_val = 0;
  bit  held_sat = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void clear_vec();
    for (int b = 0; b < 16; b++)
      for (int k = 0; k < LANES; k++) begin
        vpix[b][k] = 0;
        vwt[b][k]  = 0;
      end
  endfunction

  // Whole-vector reference: exact sum, 40-bit wrap, ReLU, clip to OUT_W.
  function automatic void model_push(input int n, input bit relu);
    longint s = 0;
    longint w;
    longint hi = (64'sd1 <<< (OUT_W - 1)) - 1;
    longint lo = -(64'sd1 <<< (OUT_W - 1));
    bit     sat = 0;
    for (int b = 0; b < n; b++)
      for (int k = 0; k < LANES; k++) begin
        w = vwt[b][k];
        if (w >= (1 << (WEIGHT_W - 1))) w -= (1 << WEIGHT_W);
        s += w * vpix[b][k];
      end
    s = (s <<< 24) >>> 24;
    if (relu && s < 0) s = 0;
    if (s > hi) begin s = hi; sat = 1; end
    else if (s < lo) begin s = lo; sat = 1; end
    exp_val_q.push_back(int'(s & 64'h3FFFFFF));
    exp_sat_q.push_back(sat);
  endfunction

  task automatic send_beat(input int len, input bit relu, input int b);
    bit ok = 0;
    int t = 0;
    cfg_len  = LEN_W'(len);
    cfg_relu = relu;
    in_valid = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      in_pixels[k*PIXEL_W +: PIXEL_W]    = PIXEL_W'(vpix[b][k]);
      in_weights[k*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(vwt[b][k]);
    end
    while (!ok && t < 300) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      t++;
    end
    if (ok) last_acc_time = $time;
    chk("beat_accept", ok, 1);
    #1;
  endtask

  // Later beats scribble on cfg to show only the first beat samples it.
  task automatic send_vector(input int len, input bit relu);
    int n = (len == 0) ? 1 : len;
    model_push(n, relu);
    for (int b = 0; b < n; b++)
      send_beat((b == 0) ? len : 1, (b == 0) ? relu : !relu, b);
  endtask

  task automatic go_idle();
    in_valid = 1'b0;
    cfg_len  = '0;
    cfg_relu = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((exp_val_q.size() != 0 || out_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(name, exp_val_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (GlobalReset) begin
      if (out_valid && !prev_valid) rise_time = $time;
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_value", out_value, held_val);
        chk("hold_sat", out_sat, held_sat);
      end
      if (out_valid && out_ready) begin
        chk("result_expected", exp_val_q.size() > 0, 1);
        if (exp_val_q.size() > 0) begin
          chk("out_value", out_value, exp_val_q.pop_front());
          chk("out_sat", out_sat, exp_sat_q.pop_front());
        end
        got_val_q.push_back(int'(out_value));
        got_sat_q.push_back(out_sat);
      end
      hold_prev  = out_valid && !out_ready;
      held_val   = int'(out_value);
      held_sat   = out_sat;
      prev_valid = out_valid;
    end else begin
      hold_prev  = 0;
      prev_valid = 0;
    end
  end

  initial begin
    int  idx;
    time t0;

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_value", out_value, 0);
    chk("rst_out_sat", out_sat, 0);
    @(posedge clk); #1;
    GlobalReset = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_edge", in_ready, 1);

    // 2.0 x (0..9) = 90.0, latency check on the last beat
    clear_vec();
    for (int b = 0; b < 10; b++) begin vpix[b][0] = b; vwt[b][0] = 'h20000; end
    idx = got_val_q.size();
    send_vector(10, 0);
    go_idle();
    wait_drain("t1_drain");
    chk("t1_value", got_val_q[idx], 'h05A0000);
    chk("t1_sat", got_sat_q[idx], 0);
    chk("t1_latency", ((rise_time - 5) - last_acc_time) / 10, MUL_DELAY + 2);

    // -1.0 x 5 over 4 beats, without then with ReLU
    clear_vec();
    for (int b = 0; b < 4; b++) begin vpix[b][0] = 5; vwt[b][0] = 'h70000; end
    idx = got_val_q.size();
    send_vector(4, 0);
    send_vector(4, 1);
    go_idle();
    wait_drain("t2_drain");
    chk("t2_neg", got_val_q[idx], 'h3EC0000);
    chk("t2_relu", got_val_q[idx+1], 0);
    chk("t2_relu_sat", got_sat_q[idx+1], 0);

    // positive and negative clipping
    clear_vec();
    for (int b = 0; b < 10; b++) begin vpix[b][0] = 1023; vwt[b][0] = 'h3FFFF; end
    idx = got_val_q.size();
    send_vector(10, 0);
    for (int b = 0; b < 10; b++) vwt[b][0] = 'h40000;
    send_vector(10, 0);
    go_idle();
    wait_drain("t3_drain");
    chk("t3_pos_value", got_val_q[idx], 'h1FFFFFF);
    chk("t3_pos_sat", got_sat_q[idx], 1);
    chk("t3_neg_value", got_val_q[idx+1], 'h2000000);
    chk("t3_neg_sat", got_sat_q[idx+1], 1);

    // three back-to-back len=2 vectors under 20 cycles of backpressure
    idx = got_val_q.size();
    out_ready = 1'b0;
    t0 = $time;
    clear_vec();
    vwt[0][0] = 'h10000; vwt[1][0] = 'h10000;
    vpix[0][0] = 0; vpix[1][0] = 1;
    send_vector(2, 0);
    vpix[0][0] = 1; vpix[1][0] = 1;
    send_vector(2, 0);
    vpix[0][0] = 1; vpix[1][0] = 2;
    send_vector(2, 0);
    go_idle();
    while ($time < t0 + 200) @(posedge clk);
    @(negedge clk);
    chk("t4_in_ready_low", in_ready, 0);
    chk("t4_out_valid", out_valid, 1);
    chk("t4_out_held", out_value, 'h10000);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("t4_drain");
    chk("t4_count", got_val_q.size() - idx, 3);
    chk("t4_r0", got_val_q[idx], 'h10000);
    chk("t4_r1", got_val_q[idx+1], 'h20000);
    chk("t4_r2", got_val_q[idx+2], 'h30000);

    // four lanes, pixel = beat + lane, weight 1.0
    clear_vec();
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < LANES; k++) begin vpix[b][k] = b + k; vwt[b][k] = 'h10000; end
    idx = got_val_q.size();
    send_vector(3, 0);
    go_idle();
    wait_drain("t5_drain");
    chk("t5_value", got_val_q[idx], 'h1E0000);

    // cfg_len = 0 acts as a single-beat vector
    clear_vec();
    vpix[0][0] = 7; vwt[0][0] = 'h10000;
    idx = got_val_q.size();
    send_vector(0, 0);
    go_idle();
    wait_drain("t6_drain");
    chk("t6_value", got_val_q[idx], 'h70000);

    // reset mid-vector discards the partial vector
    clear_vec();
    for (int b = 0; b < 10; b++) begin vpix[b][0] = 1; vwt[b][0] = 'h10000; end
    for (int b = 0; b < 5; b++) send_beat(10, 0, b);
    go_idle();
    repeat (2) @(posedge clk);
    #1;
    GlobalReset = 1'b0;
    #1;
    chk("t7_rst_out_valid", out_valid, 0);
    chk("t7_rst_in_ready", in_ready, 0);
    chk("t7_rst_out_value", out_value, 0);
    chk("t7_rst_out_sat", out_sat, 0);
    repeat (3) @(posedge clk);
    #1;
    GlobalReset = 1'b1;
    @(posedge clk); #1;
    idx = got_val_q.size();
    send_vector(10, 0);
    go_idle();
    wait_drain("t7_drain");
    repeat (20) @(posedge clk);
    #1;
    chk("t7_count", got_val_q.size() - idx, 1);
    if (got_val_q.size() > idx) chk("t7_value", got_val_q[idx], 'hA0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
